servo_pwm_bank: RTL and testbench

Parametrised multi-channel servo pulse generator with a shared frame timer. Each channel has a write-addressed target position, optional per-frame slew limiting, and a pulse width of BASE + pos·SCALE clock cycles. Width clamps to the frame length. Targets are applied only at frame boundaries, so no pulse is ever truncated or doubled. It sits between the control/register logic and the GPIO servo pins, replacing per-servo single-channel controllers.

---
 rtl/servo_pwm_bank.sv | 105 ++++++++++
 tb/tb_servo_pwm_bank.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo pulse generator sharing one frame timer.
// Targets are latched per channel and applied only at frame boundaries.
module servo_pwm_bank #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned POS_W        = 8,
  parameter int unsigned CNT_W        = 21,
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned BASE_CYCLES  = 29200,
  parameter int unsigned SCALE        = 355,
  parameter int unsigned SLEW_MAX     = 0,
  parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [POS_W-1:0]  wr_pos,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] pwm,
  output logic              frame_start,
  output logic [NUM_CH-1:0] at_target
);

  localparam int unsigned WW = CNT_W + POS_W + 1;
  localparam logic [WW-1:0] BaseW  = WW'(BASE_CYCLES);
  localparam logic [WW-1:0] FrameW = WW'(FRAME_CYCLES);
  localparam logic [WW-1:0] ScaleW = WW'(SCALE);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] ResetWidth =
      CNT_W'((BASE_CYCLES < FRAME_CYCLES) ? BASE_CYCLES : FRAME_CYCLES);

  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [POS_W-1:0]  target_q [NUM_CH];
  logic [POS_W-1:0]  cur_q    [NUM_CH];
  logic [POS_W-1:0]  cur_d    [NUM_CH];
  logic [POS_W-1:0]  diff     [NUM_CH];
  logic [WW-1:0]     wide     [NUM_CH];
  logic [CNT_W-1:0]  width_q  [NUM_CH];
  logic [CNT_W-1:0]  width_d  [NUM_CH];
  logic [NUM_CH-1:0] en_lat_q;
  logic [NUM_CH-1:0] pwm_q;
  logic [NUM_CH-1:0] at_target_q;
  logic              frame_start_q;
  logic              boundary;
  logic              wr_hit;

  assign boundary = (fcnt_q == LastCnt);
  assign fcnt_d   = boundary ? '0 : fcnt_q + 1'b1;
  // Out-of-range channel indices are silently dropped.
  assign wr_hit   = wr_en && (32'(wr_ch) < NUM_CH);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      diff[c] = (target_q[c] >= cur_q[c]) ? target_q[c] - cur_q[c] : cur_q[c] - target_q[c];
      if (SLEW_MAX == 0 || 32'(diff[c]) <= SLEW_MAX) begin
        cur_d[c] = target_q[c];
      end else if (target_q[c] > cur_q[c]) begin
        cur_d[c] = cur_q[c] + POS_W'(SLEW_MAX);
      end else begin
        cur_d[c] = cur_q[c] - POS_W'(SLEW_MAX);
      end
      // Widened so the product cannot wrap before the clamp.
      wide[c]    = BaseW + WW'(cur_d[c]) * ScaleW;
      width_d[c] = (wide[c] >= FrameW) ? CNT_W'(FrameW) : CNT_W'(wide[c]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q        <= '0;
      en_lat_q      <= '0;
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      at_target_q   <= '1;
      for (int c = 0; c < NUM_CH; c++) begin
        target_q[c] <= '0;
        cur_q[c]    <= '0;
        width_q[c]  <= ResetWidth;
      end
    end else begin
      fcnt_q        <= fcnt_d;
      frame_start_q <= (fcnt_q == '0);
      if (boundary) begin
        en_lat_q <= ch_en;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_hit && (wr_ch == CH_W'(c))) begin
          target_q[c] <= wr_pos;
        end
        // Boundary update reads pre-edge targets, so a boundary-cycle write waits a frame.
        if (boundary) begin
          cur_q[c]   <= cur_d[c];
          width_q[c] <= width_d[c];
        end
        pwm_q[c]       <= en_lat_q[c] & (fcnt_q < width_q[c]);
        at_target_q[c] <= (cur_q[c] == target_q[c]);
      end
    end
  end

  assign pwm         = pwm_q;
  assign frame_start = frame_start_q;
  assign at_target   = at_target_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: three instances (plain, slew-limited, clamping) share stimulus;
// expected per-frame pulse widths are queued with the stimulus and popped as frames complete.
module tb_servo_pwm_bank;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [3:0] wr_pos;
  logic [2:0] ch_en;
  logic [2:0] pwm_a, pwm_b, pwm_c;
  logic [2:0] at_a, at_b, at_c;
  logic       fs_a, fs_b, fs_c;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  servo_pwm_bank #(
    .NUM_CH(3), .POS_W(4), .CNT_W(8), .FRAME_CYCLES(100), .BASE_CYCLES(10), .SCALE(2),
    .SLEW_MAX(0)
  ) u_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos), .ch_en(ch_en),
    .pwm(pwm_a), .frame_start(fs_a), .at_target(at_a)
  );

  servo_pwm_bank #(
    .NUM_CH(3), .POS_W(4), .CNT_W(8), .FRAME_CYCLES(100), .BASE_CYCLES(10), .SCALE(2),
    .SLEW_MAX(4)
  ) u_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos), .ch_en(ch_en),
    .pwm(pwm_b), .frame_start(fs_b), .at_target(at_b)
  );

  servo_pwm_bank #(
    .NUM_CH(3), .POS_W(4), .CNT_W(8), .FRAME_CYCLES(100), .BASE_CYCLES(10), .SCALE(10),
    .SLEW_MAX(0)
  ) u_c (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos), .ch_en(ch_en),
    .pwm(pwm_c), .frame_start(fs_c), .at_target(at_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Order: a0 a1 a2 b0 b1 b2 c0 c1 c2
  task automatic push_frame(input int a0, input int a1, input int a2, input int b0,
                            input int b1, input int b2, input int c0, input int c1,
                            input int c2);
    exp_q.push_back(a0); exp_q.push_back(a1); exp_q.push_back(a2);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    exp_q.push_back(c0); exp_q.push_back(c1); exp_q.push_back(c2);
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    while (fs_a !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, " sync"}, int'(fs_a === 1'b1), 1);
  endtask

  // Called on the sample where frame_start is seen; returns on the next frame's first sample.
  task automatic measure_frame(input string tag, input int wr_at, input int ch, input int pos,
                               input int at_i, input logic [8:0] at_exp);
    int   cnt [9];
    bit   low [9];
    bit   brk [9];
    int   fs_err = 0;
    int   e;
    logic [8:0] p;
    for (int k = 0; k < 9; k++) begin
      cnt[k] = 0; low[k] = 1'b0; brk[k] = 1'b0;
    end
    for (int i = 0; i < 100; i++) begin
      p = {pwm_c, pwm_b, pwm_a};
      for (int k = 0; k < 9; k++) begin
        if (p[k] === 1'b1) begin
          if (low[k]) brk[k] = 1'b1;
          cnt[k]++;
        end else begin
          low[k] = 1'b1;
        end
      end
      if ({fs_a, fs_b, fs_c} !== ((i == 0) ? 3'b111 : 3'b000)) fs_err++;
      if (i == at_i) check({tag, " at_target"}, int'({at_c, at_b, at_a}), int'(at_exp));
      if (i == wr_at) begin
        wr_en  = 1'b1;
        wr_ch  = 2'(ch);
        wr_pos = 4'(pos);
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    check({tag, " frame_start"}, fs_err, 0);
    for (int k = 0; k < 9; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
      check($sformatf("%s width%0d", tag, k), brk[k] ? -1 : cnt[k], e);
    end
  endtask

  initial begin
    reset  = 1'b1;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_pos = '0;
    ch_en  = 3'b111;

    @(negedge clk);
    check("reset pwm", int'({pwm_c, pwm_b, pwm_a}), 0);
    check("reset at_target", int'({at_c, at_b, at_a}), 9'h1ff);
    check("reset frame_start", int'({fs_c, fs_b, fs_a}), 0);
    @(negedge clk);
    reset = 1'b0;

    wait_fs("f1");
    push_frame(0, 0, 0, 0, 0, 0, 0, 0, 0);
    measure_frame("f1", -1, 0, 0, 10, 9'h1ff);

    push_frame(10, 10, 10, 10, 10, 10, 10, 10, 10);
    measure_frame("f2", 49, 1, 15, 55, 9'b101_101_101);

    push_frame(10, 40, 10, 10, 18, 10, 10, 100, 10);
    measure_frame("f3", 98, 0, 5, 10, 9'b111_101_111);

    push_frame(10, 40, 10, 10, 26, 10, 10, 100, 10);
    measure_frame("f4", -1, 0, 0, 10, 9'b110_100_110);

    push_frame(20, 40, 10, 18, 34, 10, 60, 100, 10);
    measure_frame("f5", 30, 3, 7, 10, 9'b111_100_111);

    push_frame(20, 40, 10, 20, 40, 10, 60, 100, 10);
    measure_frame("f6", -1, 0, 0, 10, 9'h1ff);

    for (int i = 0; i < 4; i++) @(negedge clk);
    check("pre-reset pwm high", int'({pwm_c, pwm_b, pwm_a}), 9'h1ff);
    reset = 1'b1;
    #1;
    check("async reset pwm", int'({pwm_c, pwm_b, pwm_a}), 0);
    check("async reset frame_start", int'({fs_c, fs_b, fs_a}), 0);
    check("async reset at_target", int'({at_c, at_b, at_a}), 9'h1ff);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    wait_fs("r1");
    push_frame(0, 0, 0, 0, 0, 0, 0, 0, 0);
    measure_frame("r1", -1, 0, 0, 10, 9'h1ff);

    push_frame(10, 10, 10, 10, 10, 10, 10, 10, 10);
    measure_frame("r2", -1, 0, 0, 10, 9'h1ff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
